// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO, programmable
// bit period (latched per frame) and a level TX-done interrupt.
module io_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   input  logic        io_we,
   output logic [31:0] io_rdata,
   output logic        uart_tx,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
   logic [4:0]      count, count_nxt;
   logic            overflow, overflow_nxt;
   logic [15:0]     divisor, divisor_nxt, div_lat, div_lat_nxt;
   logic [15:0]     baud_cnt, baud_nxt;
   logic [2:0]      bit_cnt, bit_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic            tx_nxt, irq_nxt, irq_en, irq_en_nxt;
   logic            in_win, wr_tx, wr_st, wr_div, wr_ctrl;
   logic            full, empty, busy, push, pop, baud_done;
   logic [1:0]      off;
   logic            unused_bits;

   assign in_win      = (io_addr[31:4] == BASE_ADDR[31:4]);
   assign off         = io_addr[3:2];
   assign wr_tx       = io_we & in_win & (off == 2'd0);
   assign wr_st       = io_we & in_win & (off == 2'd1);
   assign wr_div      = io_we & in_win & (off == 2'd2);
   assign wr_ctrl     = io_we & in_win & (off == 2'd3);
   assign full        = (count == 5'(FIFO_DEPTH));
   assign empty       = (count == 5'd0);
   assign busy        = (state != IDLE);
   assign baud_done   = (baud_cnt == (div_lat - 16'd1));
   assign unused_bits = ^{io_wdata[31:16], io_addr[1:0]};

   // Frame sequencer: next state, bit timing, shift register and pop request.
   always_comb begin
      state_nxt   = state;
      baud_nxt    = baud_cnt + 16'd1;
      bit_nxt     = bit_cnt;
      shreg_nxt   = shreg;
      tx_nxt      = uart_tx;
      div_lat_nxt = div_lat;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt = 16'd0;
            if (!empty) begin
               pop         = 1'b1;
               state_nxt   = START;
               shreg_nxt   = mem[rd_ptr];
               div_lat_nxt = divisor;
               tx_nxt      = 1'b0;
            end else begin
               tx_nxt = 1'b1;
            end
         end
         START: begin
            if (baud_done) begin
               state_nxt = DATA;
               baud_nxt  = 16'd0;
               bit_nxt   = 3'd0;
               tx_nxt    = shreg[0];
               shreg_nxt = {1'b0, shreg[7:1]};
            end else begin
               state_nxt = START;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_nxt = 16'd0;
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_nxt   = bit_cnt + 3'd1;
                  tx_nxt    = shreg[0];
                  shreg_nxt = {1'b0, shreg[7:1]};
               end
            end else begin
               state_nxt = DATA;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_nxt = 16'd0;
               if (!empty) begin
                  pop         = 1'b1;
                  state_nxt   = START;
                  shreg_nxt   = mem[rd_ptr];
                  div_lat_nxt = divisor;
                  tx_nxt      = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  tx_nxt    = 1'b1;
               end
            end else begin
               state_nxt = STOP;
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   // FIFO bookkeeping and register writes; a full push survives only alongside a pop.
   always_comb begin
      push       = wr_tx & (~full | pop);
      wr_ptr_nxt = push ? (wr_ptr + AW'(1)) : wr_ptr;
      rd_ptr_nxt = pop ? (rd_ptr + AW'(1)) : rd_ptr;
      case ({push, pop})
         2'b10:   count_nxt = count + 5'd1;
         2'b01:   count_nxt = count - 5'd1;
         default: count_nxt = count;
      endcase
      if (wr_tx & full & ~pop) begin
         overflow_nxt = 1'b1;
      end else if (wr_st & io_wdata[3]) begin
         overflow_nxt = 1'b0;
      end else begin
         overflow_nxt = overflow;
      end
      if (wr_div) begin
         divisor_nxt = (io_wdata[15:0] == 16'd0) ? 16'd1 : io_wdata[15:0];
      end else begin
         divisor_nxt = divisor;
      end
      irq_en_nxt = wr_ctrl ? io_wdata[0] : irq_en;
      irq_nxt    = irq_en_nxt & (count_nxt == 5'd0) & (state_nxt == IDLE);
   end

   // State and register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         uart_tx  <= 1'b1;
         irq      <= 1'b0;
         wr_ptr   <= AW'(0);
         rd_ptr   <= AW'(0);
         count    <= 5'd0;
         overflow <= 1'b0;
         divisor  <= DEFAULT_DIV;
         div_lat  <= DEFAULT_DIV;
         irq_en   <= 1'b0;
         baud_cnt <= 16'd0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'd0;
      end else begin
         state    <= state_nxt;
         uart_tx  <= tx_nxt;
         irq      <= irq_nxt;
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         overflow <= overflow_nxt;
         divisor  <= divisor_nxt;
         div_lat  <= div_lat_nxt;
         irq_en   <= irq_en_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= shreg_nxt;
      end
   end

   // FIFO storage; pointers are reset, contents need not be.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= io_wdata[7:0];
      end
   end

   // Combinational register read-back.
   always_comb begin
      io_rdata = 32'd0;
      if (in_win) begin
         case (off)
            2'd0:    io_rdata = 32'd0;
            2'd1:    io_rdata = {23'd0, count, overflow, busy, empty, full};
            2'd2:    io_rdata = {16'd0, divisor};
            2'd3:    io_rdata = {31'd0, irq_en};
            default: io_rdata = 32'd0;
         endcase
      end else begin
         io_rdata = 32'd0;
      end
   end
endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: directed spec scenarios plus random traffic,
// checked every cycle against a frame-timing reference model.
module tb_io_uart_tx;
   localparam logic [31:0] BASE   = 32'hFFFF_F000;
   localparam int          DEPTH  = 8;
   localparam logic [31:0] A_TX   = BASE;
   localparam logic [31:0] A_ST   = BASE + 32'd4;
   localparam logic [31:0] A_DIV  = BASE + 32'd8;
   localparam logic [31:0] A_CTRL = BASE + 32'd12;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic [31:0] io_addr  = 32'd0;
   logic [31:0] io_wdata = 32'd0;
   logic        io_we    = 1'b0;
   logic [31:0] io_rdata;
   logic        uart_tx;
   logic        irq;

   io_uart_tx #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH),
      .DEFAULT_DIV(16'd868)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_addr (io_addr),
      .io_wdata(io_wdata),
      .io_we   (io_we),
      .io_rdata(io_rdata),
      .uart_tx (uart_tx),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: queued bytes plus the start edge and period of the current frame.
   logic [7:0]  m_q[$];
   bit          m_active = 1'b0;
   int unsigned m_start  = 0;
   int unsigned m_d      = 1;
   int unsigned cyc      = 0;
   logic [7:0]  m_byte   = 8'd0;
   logic [15:0] m_div    = 16'd868;
   bit          m_ovf    = 1'b0;
   bit          m_irq_en = 1'b0;
   bit          m_irq    = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic m_line();
      int unsigned k;
      if (!m_active) return 1'b1;
      k = (cyc - m_start) / m_d;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_byte[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] o;
      if (a < BASE || a > BASE + 32'd15) return 32'd0;
      o = (a - BASE) >> 2;
      case (o)
         32'd1:   return {23'd0, 5'(m_q.size()), m_ovf, m_active, (m_q.size() == 0), (m_q.size() == DEPTH)};
         32'd2:   return {16'd0, m_div};
         32'd3:   return {31'd0, m_irq_en};
         default: return 32'd0;
      endcase
   endfunction

   // Applies one rising edge to the model using the inputs the DUT just sampled.
   task automatic model_step();
      logic [31:0] o;
      cyc++;
      if (!rst_n) begin
         m_q.delete();
         m_active = 1'b0;
         m_ovf    = 1'b0;
         m_div    = 16'd868;
         m_irq_en = 1'b0;
         m_irq    = 1'b0;
         return;
      end
      if (m_active && cyc == m_start + 10 * m_d) m_active = 1'b0;
      if (!m_active && m_q.size() > 0) begin
         m_byte   = m_q.pop_front();
         m_start  = cyc;
         m_d      = m_div;
         m_active = 1'b1;
      end
      if (io_we && io_addr >= BASE && io_addr <= BASE + 32'd15) begin
         o = (io_addr - BASE) >> 2;
         case (o)
            32'd0: begin
               if (m_q.size() < DEPTH) m_q.push_back(io_wdata[7:0]);
               else m_ovf = 1'b1;
            end
            32'd1:   if (io_wdata[3]) m_ovf = 1'b0;
            32'd2:   m_div = (io_wdata[15:0] == 16'd0) ? 16'd1 : io_wdata[15:0];
            default: m_irq_en = io_wdata[0];
         endcase
      end
      m_irq = m_irq_en && (m_q.size() == 0) && !m_active;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("uart_tx", 32'(uart_tx), 32'(m_line()));
      check_eq("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      io_addr  = a;
      io_wdata = d;
      io_we    = 1'b1;
      tick();
      io_we    = 1'b0;
      io_addr  = 32'd0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      io_we   = 1'b0;
      io_addr = a;
      #1;
      d       = io_rdata;
      io_addr = 32'd0;
   endtask

   task automatic read_const(input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] v;
      rd(a, v);
      check_eq(tag, v, exp);
   endtask

   task automatic read_model(input logic [31:0] a, input string tag);
      logic [31:0] v;
      rd(a, v);
      check_eq(tag, v, m_read(a));
   endtask

   logic [31:0] v;
   int unsigned busy_cnt, push_cyc, rise;
   logic [7:0]  a5;

   initial begin
      // Reset values
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      read_const(A_ST, 32'h0000_0002, "rst_status");
      read_const(A_DIV, 32'h0000_0364, "rst_div");
      read_const(A_CTRL, 32'h0000_0000, "rst_ctrl");
      check_eq("rst_tx", 32'(uart_tx), 32'd1);
      check_eq("rst_irq", 32'(irq), 32'd0);

      // Single frame of 0xA5 at D=4, compared bit by bit against the 8N1 layout
      do_write(A_DIV, 32'd4);
      do_write(A_TX, 32'h0000_00A5);
      a5 = 8'hA5;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (i / 4 == 0) check_eq("frame_start", 32'(uart_tx), 32'd0);
         else if (i / 4 <= 8) check_eq("frame_data", 32'(uart_tx), 32'(a5[i/4-1]));
         else check_eq("frame_stop", 32'(uart_tx), 32'd1);
      end
      read_const(A_ST, 32'h0000_0006, "busy_at_40");
      tick();
      read_const(A_ST, 32'h0000_0002, "idle_at_41");

      // Back-to-back frames at D=2: exactly 60 busy cycles
      do_write(A_DIV, 32'd2);
      busy_cnt = 0;
      do_write(A_TX, 32'h01);
      rd(A_ST, v); busy_cnt += v[2];
      do_write(A_TX, 32'h02);
      rd(A_ST, v); busy_cnt += v[2];
      do_write(A_TX, 32'h03);
      rd(A_ST, v); busy_cnt += v[2];
      check_eq("b2b_count2", 32'(v[8:4]), 32'd2);
      for (int i = 0; i < 80; i++) begin
         tick();
         rd(A_ST, v);
         check_eq("b2b_status", v, m_read(A_ST));
         busy_cnt += v[2];
      end
      check_eq("b2b_busy_cycles", busy_cnt, 32'd60);

      // Overflow at D=100: 1 popped, 8 queued, 10th dropped
      do_write(A_DIV, 32'd100);
      for (int i = 0; i < 10; i++) do_write(A_TX, 32'($urandom_range(0, 255)));
      read_const(A_ST, 32'h0000_008D, "ovf_status");
      do_write(A_ST, 32'h0000_0008);
      read_const(A_ST, 32'h0000_0085, "ovf_clear");
      do_write(A_DIV, 32'd2);
      idle(1200);
      read_const(A_ST, 32'h0000_0002, "ovf_drained");

      // IRQ and divisor latching: frame at D=3 stays 30 cycles despite mid-frame D=5
      do_write(A_DIV, 32'd3);
      do_write(A_TX, 32'h5A);
      push_cyc = cyc;
      do_write(A_CTRL, 32'd1);
      check_eq("irq_busy_low", 32'(irq), 32'd0);
      idle(8);
      do_write(A_DIV, 32'd5);
      read_const(A_DIV, 32'd5, "div_readback");
      rise = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (irq && rise == 0) rise = cyc;
      end
      check_eq("irq_rise_edge", rise - push_cyc, 32'd31);
      check_eq("irq_high", 32'(irq), 32'd1);
      do_write(A_TX, 32'hC3);
      check_eq("irq_drop", 32'(irq), 32'd0);
      idle(60);
      do_write(A_DIV, 32'd0);
      read_const(A_DIV, 32'd1, "div_zero");

      // Decode boundary: out-of-window writes change nothing and read 0
      do_write(32'd0, 32'hFFFF_FFFF);
      do_write(BASE + 32'h10, 32'h0000_0055);
      do_write(BASE + 32'h18, 32'd7);
      read_const(32'd0, 32'd0, "rd_addr0");
      read_const(BASE + 32'h10, 32'd0, "rd_base10");
      read_const(A_DIV, 32'd1, "div_untouched");
      read_model(A_ST, "decode_status");

      // Random traffic
      do_write(A_CTRL, 32'($urandom_range(0, 1)));
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 30) begin
            do_write(A_TX + 32'($urandom_range(0, 3)), $urandom);
         end else if (r < 34) begin
            do_write(A_DIV, 32'($urandom_range(0, 5)));
         end else if (r < 37) begin
            do_write(A_CTRL, $urandom);
         end else if (r < 40) begin
            do_write(A_ST, $urandom);
         end else if (r < 50) begin
            case ($urandom_range(0, 5))
               0:       read_model(A_ST + 32'($urandom_range(0, 3)), "rand_status");
               1:       read_model(A_DIV, "rand_div");
               2:       read_model(A_CTRL, "rand_ctrl");
               3:       read_model(A_TX, "rand_txdata");
               4:       read_model(BASE - 32'd4, "rand_below");
               default: read_model(BASE + 32'h10 + 32'($urandom_range(0, 15)), "rand_above");
            endcase
            tick();
         end else begin
            tick();
         end
      end

      // Reset mid-DATA aborts the frame and empties the FIFO on that edge
      do_write(A_CTRL, 32'd0);
      do_write(A_ST, 32'h8);
      do_write(A_DIV, 32'd4);
      idle(600);
      read_const(A_ST, 32'h0000_0002, "pre_rst_idle");
      do_write(A_TX, 32'h3C);
      do_write(A_TX, 32'hC3);
      idle(8);
      read_const(A_ST, 32'h0000_0014, "mid_data_status");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("rst_mid_tx", 32'(uart_tx), 32'd1);
      read_const(A_ST, 32'h0000_0002, "rst_mid_status");
      idle(50);
      read_const(A_DIV, 32'h0000_0364, "rst_mid_div");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
